// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared defaults and helpers for the buffered I/O port controller
package io_port_pkg;

    localparam int IO_DATA_W      = 16;
    localparam int IO_DEPTH       = 4;
    localparam int IO_NUM_PORTS   = 2;
    localparam int IO_STALL_CNT_W = 16;

    // channel-select width: at least one bit even for a single channel
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - synchronous FIFO with push/pop/full/empty/head/count, async active-high reset
module io_fifo
    import io_port_pkg::*;
#(
    parameter  int DATA_W = IO_DATA_W,
    parameter  int DEPTH  = IO_DEPTH,
    localparam int AW     = $clog2(DEPTH),
    localparam int CNT_W  = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    // full blocks a push even when a pop happens on the same edge
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // storage write; contents need no reset since head is masked while empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // pointer and occupancy update; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - buffered multi-channel IN/OUT port controller with pipeline stall; optional IO_PORT_STATS_EN stall counter
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter  int DATA_W    = IO_DATA_W,
    parameter  int DEPTH     = IO_DEPTH,
    parameter  int NUM_PORTS = IO_NUM_PORTS,
    localparam int SEL_W     = sel_width(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          ext_in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0]   ext_in_data,
    output logic [NUM_PORTS-1:0]          ext_in_ready,
    input  logic                          in_req,
    input  logic [SEL_W-1:0]              in_sel,
    output logic [DATA_W-1:0]             in_rd_data,
    input  logic                          out_req,
    input  logic [SEL_W-1:0]              out_sel,
    input  logic [DATA_W-1:0]             out_wr_data,
    output logic                          stall,
    output logic [NUM_PORTS-1:0]          ext_out_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   ext_out_data,
    input  logic [NUM_PORTS-1:0]          ext_out_ack,
    output logic [IO_STALL_CNT_W-1:0]     stall_cycles
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_PORTS-1:0] w_in_full;
    logic [NUM_PORTS-1:0] w_in_empty;
    logic [NUM_PORTS-1:0] w_in_pop;
    logic [DATA_W-1:0]    w_in_head [NUM_PORTS];
    logic [CNT_W-1:0]     w_in_cnt  [NUM_PORTS];

    logic [NUM_PORTS-1:0] w_out_full;
    logic [NUM_PORTS-1:0] w_out_empty;
    logic [NUM_PORTS-1:0] w_out_push;
    logic [CNT_W-1:0]     w_out_cnt [NUM_PORTS];

    logic                 w_sel_in_empty;
    logic                 w_sel_out_full;
    logic [DATA_W-1:0]    w_sel_in_head;

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_chan
            // producer-facing input FIFO; popped by IN instructions in decode
            assign w_in_pop[g] = in_req & (in_sel == SEL_W'(g)) & ~w_in_empty[g];

            io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
                .clk         (clk),
                .rst         (reset),
                .i_push      (ext_in_valid[g]),
                .i_push_data (ext_in_data[g*DATA_W +: DATA_W]),
                .i_pop       (w_in_pop[g]),
                .o_full      (w_in_full[g]),
                .o_empty     (w_in_empty[g]),
                .o_head      (w_in_head[g]),
                .o_count     (w_in_cnt[g])
            );

            // consumer-facing output FIFO; pushed by OUT instructions in execute
            assign w_out_push[g] = out_req & (out_sel == SEL_W'(g)) & ~w_out_full[g];

            io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
                .clk         (clk),
                .rst         (reset),
                .i_push      (w_out_push[g]),
                .i_push_data (out_wr_data),
                .i_pop       (ext_out_ack[g]),
                .o_full      (w_out_full[g]),
                .o_empty     (w_out_empty[g]),
                .o_head      (ext_out_data[g*DATA_W +: DATA_W]),
                .o_count     (w_out_cnt[g])
            );

            assign ext_in_ready[g]  = ~w_in_full[g];
            assign ext_out_valid[g] = ~w_out_empty[g];
        end
    endgenerate

    // channel select: a select beyond NUM_PORTS matches nothing, so it neither stalls nor returns data
    always_comb begin
        w_sel_in_empty = 1'b0;
        w_sel_in_head  = '0;
        w_sel_out_full = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_in_empty = (w_in_cnt[k] == '0);
                w_sel_in_head  = w_in_head[k];
            end
            if (out_sel == SEL_W'(k)) begin
                w_sel_out_full = (w_out_cnt[k] == CNT_W'(DEPTH));
            end
        end
    end

    assign in_rd_data = w_sel_in_head;
    assign stall      = (in_req & w_sel_in_empty) | (out_req & w_sel_out_full);

`ifdef IO_PORT_STATS_EN
    logic [IO_STALL_CNT_W-1:0] r_stall_cycles;

    // saturating count of stalled cycles, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule
